// File: rtl/alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : RV32I execute-stage integer ALU with a combinational result
//            and a registered copy. Define ALU_EXT_OPS_EN to add XOR/SLTU.
// Revision : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             last_bit,
    output logic [WIDTH-1:0] alu_result_q,
    output logic             zero_q,
    output logic             last_bit_q
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_SLT  = 3'b101;
`ifdef ALU_EXT_OPS_EN
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_SLTU = 3'b110;
`endif

    logic [WIDTH:0]   w_diff_s;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_last_bit;
`ifdef ALU_EXT_OPS_EN
    logic             w_ltu;
`endif

    logic [WIDTH-1:0] r_alu_result_q;
    logic             r_zero_q;
    logic             r_last_bit_q;

    // Subtracting sign-extended operands one bit wider cannot overflow, so
    // bit WIDTH is the true signed less-than; low bits double as SUB.
    assign w_diff_s = {src1[WIDTH-1], src1} - {src2[WIDTH-1], src2};

`ifdef ALU_EXT_OPS_EN
    assign w_ltu = (src1 < src2);
`endif

    always_comb begin
        w_result = '0;
        unique case (alu_control)
            c_OP_ADD:  w_result = src1 + src2;
            c_OP_SUB:  w_result = w_diff_s[WIDTH-1:0];
            c_OP_AND:  w_result = src1 & src2;
            c_OP_OR:   w_result = src1 | src2;
            c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_diff_s[WIDTH]};
`ifdef ALU_EXT_OPS_EN
            c_OP_XOR:  w_result = src1 ^ src2;
            c_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_ltu};
`endif
            default:   w_result = '0;
        endcase
    end

    assign w_zero     = (w_result == '0);
    assign w_last_bit = w_result[WIDTH-1];

    assign alu_result = w_result;
    assign zero       = w_zero;
    assign last_bit   = w_last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_result_q <= '0;
            r_zero_q       <= 1'b0;
            r_last_bit_q   <= 1'b0;
        end else begin
            r_alu_result_q <= w_result;
            r_zero_q       <= w_zero;
            r_last_bit_q   <= w_last_bit;
        end
    end

    assign alu_result_q = r_alu_result_q;
    assign zero_q       = r_zero_q;
    assign last_bit_q   = r_last_bit_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu; random stimulus against a
//            behavioural model (honours ALU_EXT_OPS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic        last_bit;
    logic [31:0] alu_result_q;
    logic        zero_q;
    logic        last_bit_q;

    int vectors;
    int errors;

    alu #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src1         (src1),
        .src2         (src2),
        .alu_control  (alu_control),
        .alu_result   (alu_result),
        .zero         (zero),
        .last_bit     (last_bit),
        .alu_result_q (alu_result_q),
        .zero_q       (zero_q),
        .last_bit_q   (last_bit_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model written straight from the operation definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
            3'd4: return a ^ b;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        src1 = 32'd10; src2 = 32'd20; alu_control = 3'd0;
        #1;
        vectors++;
        if ({alu_result_q, zero_q, last_bit_q} !== 34'd0) begin
            errors++;
            $display("FAIL reset_q got=%h/%b/%b exp=0/0/0", alu_result_q, zero_q, last_bit_q);
        end
        vectors++;
        if (alu_result !== 32'd30) begin
            errors++;
            $display("FAIL comb_in_reset got=%h exp=%h", alu_result, 32'd30);
        end
        @(posedge clk); #1;
        vectors++;
        if (alu_result_q !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold_q got=%h exp=0", alu_result_q);
        end
    endtask

    task automatic test_registers;
        @(negedge clk);
        rst_n = 1'b1;
        src1 = 32'd3; src2 = 32'd4; alu_control = 3'd0;
        #1;
        vectors++;
        if (alu_result !== 32'd7 || alu_result_q !== 32'd0) begin
            errors++;
            $display("FAIL add_3_4_pre got=%h q=%h exp=7 q=0", alu_result, alu_result_q);
        end
        @(posedge clk); #1;
        vectors++;
        if ({alu_result_q, zero_q, last_bit_q} !== {32'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_3_4_q got=%h/%b/%b exp=7/0/0", alu_result_q, zero_q, last_bit_q);
        end
        @(negedge clk);
        src1 = 32'd0; src2 = 32'd1; alu_control = 3'd1;
        @(posedge clk); #1;
        vectors++;
        if ({alu_result_q, zero_q, last_bit_q} !== {32'hFFFF_FFFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_q got=%h/%b/%b exp=ffffffff/0/1", alu_result_q, zero_q, last_bit_q);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({alu_result_q, zero_q, last_bit_q} !== 34'd0) begin
            errors++;
            $display("FAIL async_clear got=%h/%b/%b exp=0/0/0", alu_result_q, zero_q, last_bit_q);
        end
        @(posedge clk); #1;
        vectors++;
        if (alu_result_q !== 32'd0 || last_bit_q !== 1'b0) begin
            errors++;
            $display("FAIL discard_pending got=%h/%b exp=0/0", alu_result_q, last_bit_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        alu_control = 3'd7;
        @(posedge clk); #1;
        vectors++;
        if ({alu_result_q, zero_q, last_bit_q} !== {32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL first_capture got=%h/%b/%b exp=0/1/0", alu_result_q, zero_q, last_bit_q);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (zero_q !== 1'b0) begin
            errors++;
            $display("FAIL zero_q_clear got=%b exp=0", zero_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random_ops;
        logic [31:0] exp;
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                src1 = $urandom; src2 = $urandom; alu_control = 3'(op);
                #1;
                exp = model(alu_control, src1, src2);
                vectors++;
                if ({alu_result, zero, last_bit} !== {exp, exp == 32'd0, exp[31]}) begin
                    errors++;
                    $display("FAIL rand_op%0d a=%h b=%h got=%h/%b/%b exp=%h",
                             op, src1, src2, alu_result, zero, last_bit, exp);
                end
            end
        end
    endtask

    task automatic test_corners;
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd5, 3'd5};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'd0, 32'd12345, 32'd1,
                                 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] bs  [6] = '{32'd1, 32'd1, 32'hFFFF_CFC7, 32'd1,
                                 32'd1, 32'h8000_0000};
        logic [31:0] rs  [6] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd1, 32'd0};
        logic        zs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        ls  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            src1 = as[i]; src2 = bs[i]; alu_control = ops[i];
            #1;
            vectors++;
            if ({alu_result, zero, last_bit} !== {rs[i], zs[i], ls[i]}) begin
                errors++;
                $display("FAIL corner%0d got=%h/%b/%b exp=%h/%b/%b",
                         i, alu_result, zero, last_bit, rs[i], zs[i], ls[i]);
            end
        end
    endtask

    task automatic test_slt;
        logic [31:0] exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            src1 = $urandom;
            src2 = (i % 10 == 0) ? src1 : 32'($urandom);
            alu_control = 3'd5;
            #1;
            exp = model(3'd5, src1, src2);
            vectors++;
            if ({alu_result, zero, last_bit} !== {exp, exp == 32'd0, 1'b0}) begin
                errors++;
                $display("FAIL slt a=%h b=%h got=%h exp=%h", src1, src2, alu_result, exp);
            end
        end
    endtask

    task automatic test_default;
        logic [2:0] codes [3] = '{3'd7, 3'd4, 3'd6};
        logic [31:0] exp;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                src1 = $urandom; src2 = $urandom; alu_control = codes[c];
                #1;
                exp = model(codes[c], src1, src2);
                vectors++;
                if ({alu_result, zero, last_bit} !== {exp, exp == 32'd0, exp[31]}) begin
                    errors++;
                    $display("FAIL code%0d a=%h b=%h got=%h/%b/%b exp=%h",
                             codes[c], src1, src2, alu_result, zero, last_bit, exp);
                end
            end
        end
    endtask

    task automatic test_ext_ops;
        logic [31:0] exp_xor;
        logic [31:0] exp_sltu;
`ifdef ALU_EXT_OPS_EN
        exp_xor  = 32'hFF00_FF00;
        exp_sltu = 32'd1;
`else
        exp_xor  = 32'd0;
        exp_sltu = 32'd0;
`endif
        @(negedge clk);
        src1 = 32'hF0F0_F0F0; src2 = 32'h0FF0_0FF0; alu_control = 3'd4;
        #1;
        vectors++;
        if ({alu_result, zero, last_bit} !== {exp_xor, exp_xor == 32'd0, exp_xor[31]}) begin
            errors++;
            $display("FAIL code4_fixed got=%h/%b/%b exp=%h", alu_result, zero, last_bit, exp_xor);
        end
        @(negedge clk);
        src1 = 32'd1; src2 = 32'hFFFF_FFFF; alu_control = 3'd6;
        #1;
        vectors++;
        if ({alu_result, zero} !== {exp_sltu, exp_sltu == 32'd0}) begin
            errors++;
            $display("FAIL code6_fixed got=%h/%b exp=%h", alu_result, zero, exp_sltu);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            src1 = $urandom; src2 = $urandom; alu_control = 3'($urandom_range(0, 7));
            exp = model(alu_control, src1, src2);
            @(posedge clk); #1;
            vectors++;
            if ({alu_result_q, zero_q, last_bit_q} !== {exp, exp == 32'd0, exp[31]}) begin
                errors++;
                $display("FAIL b2b op=%0d a=%h b=%h got=%h/%b/%b exp=%h",
                         alu_control, src1, src2, alu_result_q, zero_q, last_bit_q, exp);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_registers();
        test_random_ops();
        test_corners();
        test_slt();
        test_default();
        test_ext_ops();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
